reu_bus_grant: RTL and testbench
================================

# reu_bus_grant

Bus-side responder for the REU DMA interface: it accepts `dma_req` from the REU, stalls the 8502 by dropping BA, and waits out the CPU write-completion window. It then opens fixed-length DMA slots (`dma_cycle`) on successive bus cycles and carries the REU address, data and write strobe onto the system bus. It sits between the REU and the C128 bus/MMU arbitration, on the opposite end of the `dma_req`/`dma_cycle` handshake from the REU.

## Interface
- `SLOT_LEN`, default 16: clk cycles per DMA slot; the REU completes a C64-side access after exactly 16 `dma_cycle` clocks.
- `BA_DELAY`, default 3: bus cycles between BA falling and the first slot.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `phi_start`  in  1  one-clk pulse marking the start of each CPU bus cycle.
- `vic_busy`  in  1  VIC owns the current bus cycle; sampled together with `phi_start`.
- `dma_req`  in  1  REU requests the bus.
- `dma_cycle`  out  1  slot active; the REU may drive the bus.
- `dma_addr`  in  16  REU C64-side address.
- `dma_dout`  in  8  REU write data.
- `dma_we`  in  1  REU write strobe, already gated by `dma_cycle`.
- `dma_din`  out  8  read data returned to the REU.
- `cpu_ba`  out  1  bus available to the CPU; 0 stalls the CPU.
- `cpu_dma`  out  1  1 = CPU address/data drivers tristated.
- `bus_addr`  out  16  system bus address.
- `bus_dout`  out  8  system bus write data.
- `bus_we`  out  1  system bus write enable.
- `bus_din`  in  8  system bus read data, valid by slot clock `SLOT_LEN-3`.

## Operation
- States:
  - IDLE: `dma_req`=1 → STALL, `cpu_ba`<=0, BA counter cleared.
  - STALL: counts `phi_start` pulses. At `BA_DELAY` pulses → GRANT, `cpu_dma`<=1. If `dma_req` falls in STALL → RELEASE.
  - GRANT: each `phi_start` with `vic_busy`=0 opens a slot.
    - A slot holds `dma_cycle`=1 for exactly `SLOT_LEN` clks.
    - `dma_req`=0 with no slot open → RELEASE.
  - RELEASE: `cpu_dma`<=0 immediately. `cpu_ba`<=1 on the next `phi_start`, then → IDLE.
- During a slot:
  - `bus_addr`=`dma_addr`, `bus_dout`=`dma_dout`, `bus_we`=`dma_we`, all registered.
  - `dma_din` <= `bus_din` on every slot clk, held between slots.
- Outside slots: `bus_addr`=0, `bus_we`=0.
- An open slot always runs to completion, even if `dma_req` falls or `phi_start` recurs mid-slot. A `phi_start` during an open slot is ignored and does not open a slot.
- Slot counter width is `$clog2(SLOT_LEN)`. `BA_DELAY` counter saturates.
- `dma_req` reasserted in RELEASE is acted on only after the return to IDLE, one clk later.

## Timing
- Reset values (asynchronous, `reset_n`=0): state IDLE, `cpu_ba`=1, `cpu_dma`=0, `dma_cycle`=0, `bus_we`=0, `bus_addr`=0, `bus_dout`=0, `dma_din`=8'hFF.
- `dma_req` rise → `cpu_ba`=0: 1 clk.
- First slot opens on the clk after the (`BA_DELAY`+1)th `phi_start` following BA low. With default parameters that is the 4th pulse.
- A slot opens 1 clk after its `phi_start`. `dma_cycle` is high on slot clocks 0..`SLOT_LEN-1`.
- `bus_*` outputs lag the REU inputs by 1 clk.
- `dma_din` reflects `bus_din` with 1 clk latency. It is stable at slot clock `SLOT_LEN-1`, where the REU samples.
- Reset asserted mid-slot: all outputs return to reset values immediately; no partial write is extended.

## Configuration
- `REU_VIC_YIELD_EN` defined: a `phi_start` with `vic_busy`=1 opens no slot, and the REU waits for the next bus cycle.
- `REU_VIC_YIELD_EN` not defined: `vic_busy` is ignored, and every `phi_start` in GRANT opens a slot.

## Structure
- Package `reu_bus_pkg`:
  - state enum `grant_state_t` (IDLE, STALL, GRANT, RELEASE).
  - default constants `REU_SLOT_LEN`=16 and `REU_BA_DELAY`=3.
- Sub-module `reu_slot_timer`: slot down-counter with `start`, `active` and `last` outputs. `reu_bus_grant` instantiates it once.

## Test plan
- `phi_start` every 32 clks, `dma_req` rises at clk 5 → `cpu_ba`=0 at clk 6. First `dma_cycle` high 1 clk after the 4th `phi_start`, for 16 clks. `cpu_dma`=1 from GRANT entry.
- Read slot, `dma_addr`=16'hD020, `bus_din`=8'h5A → `bus_addr`=16'hD020, `bus_we`=0, `dma_din`=8'h5A at slot clock 15.
- Write slot, `dma_we`=1, `dma_dout`=8'hC3 → `bus_we`=1 with `bus_dout`=8'hC3 for the slot. `bus_we`=0 the clk after the slot ends.
- `dma_req` drops at slot clock 7 → slot completes all 16 clks. `cpu_dma`=0 after the slot, and `cpu_ba`=1 at the next `phi_start`.
- With `REU_VIC_YIELD_EN`, `vic_busy`=1 on one `phi_start` → no slot that bus cycle, next one opens normally. Without the macro → a slot opens.
- `reset_n` pulsed low at slot clock 4 of a write → `bus_we`=0, `dma_cycle`=0, `cpu_ba`=1 immediately. After release, IDLE; a new `dma_req` restarts the BA delay.

Source files
------------

// File: rtl/reu_bus_grant_pkg.sv
// reu_bus_pkg: shared state encoding, default timing constants and a
// counter-width helper for the REU bus grant block.
package reu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } grant_state_t;

  localparam int REU_SLOT_LEN = 16;
  localparam int REU_BA_DELAY = 3;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reu_bus_grant_if.sv
// reu_bus_grant_if: REU DMA handshake, CPU stall controls and system bus
// signals. slave = the grant block, master = the REU / bus side.
interface reu_bus_grant_if;

  logic        phi_start;
  logic        vic_busy;
  logic        dma_req;
  logic        dma_cycle;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_we;
  logic [7:0]  dma_din;
  logic        cpu_ba;
  logic        cpu_dma;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_we;
  logic [7:0]  bus_din;

  modport slave (
    input  phi_start, vic_busy, dma_req, dma_addr, dma_dout, dma_we, bus_din,
    output dma_cycle, dma_din, cpu_ba, cpu_dma, bus_addr, bus_dout, bus_we
  );

  modport master (
    output phi_start, vic_busy, dma_req, dma_addr, dma_dout, dma_we, bus_din,
    input  dma_cycle, dma_din, cpu_ba, cpu_dma, bus_addr, bus_dout, bus_we
  );

endinterface

// File: rtl/reu_bus_grant_slot_timer.sv
// reu_slot_timer: fixed-length DMA slot down-counter. A start pulse opens a
// slot that stays active for exactly SLOT_LEN clocks; last flags the final
// clock of the slot.
module reu_slot_timer
  import reu_bus_pkg::*;
#(
  parameter int SLOT_LEN = REU_SLOT_LEN
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic active,
  output logic last
);

  localparam int            CW   = cnt_w(SLOT_LEN);
  localparam logic [CW-1:0] LOAD = CW'(SLOT_LEN - 1);

  logic [CW-1:0] cnt;

  assign last = active && (cnt == '0);

  // Load on start, count down while active, close after the zero clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= LOAD;
    end else if (active) begin
      if (last) active <= 1'b0;
      else      cnt    <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/reu_bus_grant.sv
// reu_bus_grant: bus-side responder for the REU DMA handshake. Stalls the
// CPU via BA, waits BA_DELAY bus cycles, then opens one fixed-length DMA
// slot per bus cycle and registers the REU address/data/strobe onto the bus.
// Optional build macro REU_VIC_YIELD_EN: bus cycles owned by the VIC
// (vic_busy with phi_start) open no slot.
module reu_bus_grant
  import reu_bus_pkg::*;
#(
  parameter int SLOT_LEN = REU_SLOT_LEN,
  parameter int BA_DELAY = REU_BA_DELAY   // expected >= 1
) (
  input  logic            clk,
  input  logic            reset_n,
  reu_bus_grant_if.slave  bif
);

  localparam int BW = cnt_w(BA_DELAY + 1);

  grant_state_t  state, state_nx;
  logic [BW-1:0] ba_cnt;
  logic          ba_hit;
  logic          vic_ok;
  logic          slot_start, slot_active, slot_last, slot_next;
  logic          cpu_ba_c, cpu_dma_c;
  logic [15:0]   bus_addr_q;
  logic [7:0]    bus_dout_q;
  logic          bus_we_q;
  logic [7:0]    dma_din_q;

`ifdef REU_VIC_YIELD_EN
  assign vic_ok = !bif.vic_busy;
`else
  logic unused_vic_busy;
  assign unused_vic_busy = bif.vic_busy;
  assign vic_ok          = 1'b1;
`endif

  // The phi_start that completes the BA wait moves STALL into GRANT.
  assign ba_hit = bif.phi_start && ((int'(ba_cnt) + 1) >= BA_DELAY);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state. GRANT leaves only once no slot is left running, so the
  // release can take effect on the clock right after the last slot clock.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bif.dma_req) state_nx = STALL;
      STALL:   if (!bif.dma_req) state_nx = RELEASE;
               else if (ba_hit)  state_nx = GRANT;
      GRANT:   if (!bif.dma_req && (!slot_active || slot_last)) state_nx = RELEASE;
      RELEASE: if (bif.phi_start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state; a slot opens only on a free bus cycle.
  always_comb begin
    cpu_ba_c   = (state == IDLE);
    cpu_dma_c  = (state == GRANT);
    slot_start = (state == GRANT) && bif.dma_req && bif.phi_start &&
                 !slot_active && vic_ok;
  end

  // BA wait counter: cleared while idle, saturating phi_start count in STALL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ba_cnt <= '0;
    else if (state == IDLE)
      ba_cnt <= '0;
    else if ((state == STALL) && bif.phi_start && (ba_cnt != BW'(BA_DELAY)))
      ba_cnt <= ba_cnt + 1'b1;
  end

  reu_slot_timer #(.SLOT_LEN(SLOT_LEN)) u_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (slot_start),
    .active  (slot_active),
    .last    (slot_last)
  );

  // Slot occupancy for the coming clock; gates the registered bus outputs so
  // they fall together with dma_cycle.
  assign slot_next = slot_start || (slot_active && !slot_last);

  // Bus drive one clock behind the REU; read data captured every slot clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_addr_q <= '0;
      bus_dout_q <= '0;
      bus_we_q   <= 1'b0;
      dma_din_q  <= 8'hFF;
    end else begin
      bus_addr_q <= slot_next ? bif.dma_addr : 16'h0000;
      bus_dout_q <= slot_next ? bif.dma_dout : 8'h00;
      bus_we_q   <= slot_next && bif.dma_we;
      if (slot_active) dma_din_q <= bif.bus_din;
    end
  end

  assign bif.dma_cycle = slot_active;
  assign bif.cpu_ba    = cpu_ba_c;
  assign bif.cpu_dma   = cpu_dma_c;
  assign bif.bus_addr  = bus_addr_q;
  assign bif.bus_dout  = bus_dout_q;
  assign bif.bus_we    = bus_we_q;
  assign bif.dma_din   = dma_din_q;

endmodule

// File: tb/tb_reu_bus_grant.sv
// tb_reu_bus_grant: randomized REU bursts with a scoreboard of transfers and
// a clock-level reference of slot timing derived from the bus-cycle rules.
`timescale 1ns/1ps
module tb_reu_bus_grant;

  localparam int SLOT_LEN = 16;
  localparam int BA_DELAY = 3;
  localparam int PHI_PER  = 32;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        we;
    logic [7:0]  din;
  } txn_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic reu_we  = 1'b0;
  logic phi_extra = 1'b0;
  int   phi_ctr = 0;

  int errors = 0;
  int checks = 0;

  txn_t exp_q[$];
  txn_t dir_q[$];

  reu_bus_grant_if bif();

  reu_bus_grant #(.SLOT_LEN(SLOT_LEN), .BA_DELAY(BA_DELAY)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bif     (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) phi_ctr <= (phi_ctr == PHI_PER - 1) ? 0 : phi_ctr + 1;

  assign bif.phi_start = (phi_ctr == 0) | phi_extra;
  assign bif.dma_we    = bif.dma_cycle & reu_we;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor / reference ----------------
  initial begin
    int   mrem, pcnt, k;
    bit   exp_cyc, start, vic_ok, prev_phi, prev_dma, prev_req, prev_ba;
    txn_t cur;
    logic [7:0] last_din;
    mrem = 0; pcnt = 0; prev_phi = 0; prev_dma = 0; prev_req = 0; prev_ba = 1;
    last_din = 8'hFF;
    cur = '{addr: 16'h0, dout: 8'h0, we: 1'b0, din: 8'h0};
    bif.bus_din = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_dma_cycle", bif.dma_cycle, 0);
        chk("rst_cpu_ba",    bif.cpu_ba,    1);
        chk("rst_cpu_dma",   bif.cpu_dma,   0);
        chk("rst_bus_we",    bif.bus_we,    0);
        chk("rst_bus_addr",  bif.bus_addr,  0);
        chk("rst_bus_dout",  bif.bus_dout,  0);
        chk("rst_dma_din",   bif.dma_din,   8'hFF);
        mrem = 0; pcnt = 0; last_din = 8'hFF;
        prev_phi = 0; prev_dma = 0; prev_req = 0; prev_ba = 1;
        bif.bus_din = 8'($urandom);
      end else begin
        exp_cyc = (mrem != 0);
        k       = SLOT_LEN - mrem;
        chk("dma_cycle", bif.dma_cycle, exp_cyc);
        if (exp_cyc) begin
          if (k == 0) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL slot_pop: slot opened with no queued transfer at %0t", $time);
            end else begin
              cur = exp_q.pop_front();
            end
            chk("slot_cpu_ba",  bif.cpu_ba,  0);
            chk("slot_cpu_dma", bif.cpu_dma, 1);
            chk("slot0_din_hold", bif.dma_din, last_din);
          end
          chk("bus_addr", bif.bus_addr, cur.addr);
          chk("bus_dout", bif.bus_dout, cur.dout);
          chk("bus_we",   bif.bus_we,   (k > 0) ? cur.we : 1'b0);
          if (k == SLOT_LEN - 1) begin
            chk("dma_din", bif.dma_din, cur.din);
            last_din = cur.din;
          end
        end else begin
          chk("idle_bus_addr", bif.bus_addr, 0);
          chk("idle_bus_we",   bif.bus_we,   0);
          chk("idle_din_hold", bif.dma_din,  last_din);
        end
        if (bif.cpu_dma && !prev_dma) begin
          chk("grant_phi_count", pcnt, BA_DELAY);
          chk("grant_after_phi", prev_phi, 1);
        end
        if (!bif.cpu_ba && prev_ba) chk("ba_fall_on_req", prev_req, 1);
        // phi_start pulses seen with BA low, this cycle included
        if (bif.cpu_ba) pcnt = 0;
        else if (bif.phi_start) pcnt++;
`ifdef REU_VIC_YIELD_EN
        vic_ok = !bif.vic_busy;
`else
        vic_ok = 1'b1;
`endif
        start = bif.phi_start && bif.dma_req && !exp_cyc &&
                (pcnt >= BA_DELAY + 1) && vic_ok;
        if (exp_cyc) mrem--;
        if (start)   mrem = SLOT_LEN;
        // bus memory: read data valid from slot clock SLOT_LEN-3 onward
        bif.bus_din = (exp_cyc && k >= SLOT_LEN - 3) ? cur.din : 8'($urandom);
        prev_phi = bif.phi_start;
        prev_dma = bif.cpu_dma;
        prev_req = bif.dma_req;
        prev_ba  = bif.cpu_ba;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic next_txn(output txn_t t);
    if (dir_q.size() != 0) t = dir_q.pop_front();
    else t = '{addr: 16'($urandom), dout: 8'($urandom), we: 1'($urandom), din: 8'($urandom)};
    bif.dma_addr = t.addr;
    bif.dma_dout = t.dout;
    reu_we       = t.we;
    exp_q.push_back(t);
  endtask

  task automatic wait_cycle(input logic lvl, input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bif.dma_cycle === lvl) return;
    end
    checks++; errors++;
    $display("FAIL %s: dma_cycle never reached %0b within %0d clks", name, lvl, limit);
  endtask

  task automatic wait_phi(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (bif.phi_start) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL phi_wait: no phi_start within %0d clks", limit);
  endtask

  // One REU burst of n slots; optionally one VIC-owned bus cycle before the
  // second slot and a stray phi_start inside each slot.
  task automatic burst(input int n, input bit vic_skip, input bit extra);
    txn_t t;
    int drop_k, ex_k;
    repeat ($urandom_range(1, 40)) @(posedge clk);
    #1;
    next_txn(t);
    bif.dma_req = 1'b1;
    @(negedge clk); chk("ba_before_req", bif.cpu_ba, 1);
    @(negedge clk); chk("ba_latency",    bif.cpu_ba, 0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        next_txn(t);
        if (vic_skip && i == 1) begin
          bif.vic_busy = 1'b1;
          @(negedge clk);
          wait_phi(64);
          @(posedge clk); #1 bif.vic_busy = 1'b0;
        end
      end
      wait_cycle(1'b1, 300, "slot_open");
      drop_k = (i == n - 1) ? $urandom_range(1, SLOT_LEN - 1) : SLOT_LEN;
      ex_k   = extra ? $urandom_range(2, SLOT_LEN - 3) : -1;
      for (int c = 1; c < SLOT_LEN; c++) begin
        @(posedge clk); #1;
        if (c >= drop_k) bif.dma_req = 1'b0;
        phi_extra = (c == ex_k);
      end
      wait_cycle(1'b0, 40, "slot_close");
    end
    chk("release_cpu_dma", bif.cpu_dma, 0);
    wait_phi(64);
    chk("ba_low_at_phi", bif.cpu_ba, 0);
    @(negedge clk);
    chk("ba_release", bif.cpu_ba, 1);
  endtask

  initial begin
    txn_t t;
    bif.dma_req = 1'b0; bif.vic_busy = 1'b0;
    bif.dma_addr = 16'h0; bif.dma_dout = 8'h0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    dir_q.push_back('{addr: 16'hD020, dout: 8'h00, we: 1'b0, din: 8'h5A});
    dir_q.push_back('{addr: 16'h0400, dout: 8'hC3, we: 1'b1, din: 8'h11});
    burst(2, 1'b0, 1'b0);
    burst(2, 1'b1, 1'b1);
    repeat (8) burst($urandom_range(1, 3), 1'($urandom), 1'($urandom));

    // reset asserted at slot clock 4 of a write slot
    repeat (5) @(posedge clk);
    #1;
    dir_q.push_back('{addr: 16'h1234, dout: 8'hA5, we: 1'b1, din: 8'h3C});
    next_txn(t);
    bif.dma_req = 1'b1;
    wait_cycle(1'b1, 300, "rst_slot_open");
    repeat (3) @(posedge clk);
    #1 chk("pre_rst_bus_we", bif.bus_we, 1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_bus_we",    bif.bus_we,    0);
    chk("async_rst_dma_cycle", bif.dma_cycle, 0);
    chk("async_rst_cpu_ba",    bif.cpu_ba,    1);
    chk("async_rst_cpu_dma",   bif.cpu_dma,   0);
    bif.dma_req = 1'b0;
    reu_we = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    burst(2, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
